// File: rtl/rail_seq_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rail_seq_defs (package)
// Description : Shared definitions for the rail power sequencer: FSM state
//               encodings (also decoded by the DSP sequencer debug LEDs) and
//               the width rule for the fault_rail index output.
// Revision    : 1.0 - initial release
// ============================================================================
package rail_seq_defs;

  localparam int STATE_W = 3;

  // Encodings are visible on the state output; keep them stable.
  localparam logic [STATE_W-1:0] ST_OFF    = 3'd0;
  localparam logic [STATE_W-1:0] ST_RAMP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
  localparam logic [STATE_W-1:0] ST_UP     = 3'd3;
  localparam logic [STATE_W-1:0] ST_DOWN   = 3'd4;
  localparam logic [STATE_W-1:0] ST_FAULT  = 3'd5;

  // Width of a rail index / fault_rail: $clog2(n), never below one bit.
  function automatic int fault_rail_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rail_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : rail_seq_timer
// Description : Shared cycle timer for the rail sequencer. Synchronous clear,
//               saturating increment and an equality compare against the
//               threshold currently selected by the sequencer.
// Ports       : sysclk  - clock
//               reset   - synchronous active-high reset
//               clr_i   - clear count to zero (wins over increment)
//               inc_i   - increment count by one
//               last_i  - threshold to compare against
//               last_o  - count equals last_i
// Revision    : 1.0 - initial release
// ============================================================================
module rail_seq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] last_i,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;

  // The sequencer leaves a timing state as soon as the threshold is hit, so
  // the saturation guard only protects against wrap, it never shapes timing.
  always_ff @(posedge sysclk) begin : p_count
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign last_o = (count_q == last_i);

endmodule
`default_nettype wire

// File: rtl/rail_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rail_sequencer
// Description : Power-rail sequencer. Enables rails 0..NUM_RAILS-1 in order,
//               waiting for each power-good and a settle delay, powers down
//               in strict reverse order, and drops every rail at once on a
//               power-good fault or timeout.
// Ports       : sysclk     - sole clock
//               reset      - synchronous active-high reset
//               enable     - level request for rails on
//               pg         - power-good per rail
//               rail_en    - registered regulator enable per rail
//               all_good   - high in UP
//               fault      - high in FAULT
//               fault_rail - failing rail index, valid while fault=1
//               state      - current FSM encoding
// Revision    : 1.0 - initial release
// ============================================================================
module rail_sequencer
  import rail_seq_defs::*;
#(
  parameter int NUM_RAILS     = 4,
  parameter int TIMER_WIDTH   = 16,
  parameter int PG_TIMEOUT    = 1000,
  parameter int SETTLE_CYCLES = 100
) (
  input  logic                                   sysclk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [NUM_RAILS-1:0]                   pg,
  output logic [NUM_RAILS-1:0]                   rail_en,
  output logic                                   all_good,
  output logic                                   fault,
  output logic [fault_rail_width(NUM_RAILS)-1:0] fault_rail,
  output logic [STATE_W-1:0]                     state
);

  localparam int IW = fault_rail_width(NUM_RAILS);
  localparam int LW = IW + 1;

  localparam logic [IW-1:0]          c_last_idx    = IW'(NUM_RAILS - 1);
  localparam logic [TIMER_WIDTH-1:0] c_pg_last     = TIMER_WIDTH'(PG_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] c_settle_last = TIMER_WIDTH'(SETTLE_CYCLES - 1);

  // Reject parameter sets whose thresholds do not fit the timer.
  generate
    if (NUM_RAILS < 1 || NUM_RAILS > 16) begin : g_bad_num_rails
      $fatal(1, "rail_sequencer: NUM_RAILS must be 1..16");
    end
    if (PG_TIMEOUT < 2 || 64'(PG_TIMEOUT) >= (64'd1 << TIMER_WIDTH)) begin : g_bad_pg_timeout
      $fatal(1, "rail_sequencer: PG_TIMEOUT out of range for TIMER_WIDTH");
    end
    if (SETTLE_CYCLES < 1 || 64'(SETTLE_CYCLES) >= (64'd1 << TIMER_WIDTH)) begin : g_bad_settle
      $fatal(1, "rail_sequencer: SETTLE_CYCLES out of range for TIMER_WIDTH");
    end
  endgenerate

  logic [STATE_W-1:0]     state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_RAILS-1:0]   rail_en_q, rail_en_d;
  logic [IW-1:0]          fault_rail_q, fault_rail_d;

  logic                   w_tmr_clr;
  logic                   w_tmr_inc;
  logic                   w_tmr_last;
  logic [TIMER_WIDTH-1:0] w_tmr_last_val;
  logic [IW-1:0]          w_next_idx;
  logic [IW-1:0]          w_prev_idx;
  logic [LW-1:0]          w_lim;
  logic                   w_pg_fail;
  logic [IW-1:0]          w_pg_fail_idx;

  assign w_next_idx     = idx_q + IW'(1);
  assign w_prev_idx     = idx_q - IW'(1);
  assign w_tmr_last_val = (state_q == ST_RAMP) ? c_pg_last : c_settle_last;

  rail_seq_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clr_i  (w_tmr_clr),
    .inc_i  (w_tmr_inc),
    .last_i (w_tmr_last_val),
    .last_o (w_tmr_last)
  );

  // Power-good supervision: in RAMP only rails below idx are already proven
  // good; in SETTLE/UP rail idx is included. Downward scan leaves the lowest
  // failing rail in w_pg_fail_idx.
  always_comb begin : p_pg_scan
    w_lim         = (state_q == ST_RAMP) ? {1'b0, idx_q} : ({1'b0, idx_q} + LW'(1));
    w_pg_fail     = 1'b0;
    w_pg_fail_idx = '0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if ((LW'(j) < w_lim) && !pg[j]) begin
        w_pg_fail     = 1'b1;
        w_pg_fail_idx = IW'(j);
      end
    end
  end

  // State register
  always_ff @(posedge sysclk) begin : p_state
    if (reset) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      rail_en_q    <= '0;
      fault_rail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rail_en_q    <= rail_en_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  // Next-state logic. Within each state, fault checks come first so they
  // override a simultaneous enable drop.
  always_comb begin : p_next
    state_d      = state_q;
    idx_d        = idx_q;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;
    w_tmr_clr    = 1'b0;
    w_tmr_inc    = 1'b0;

    case (state_q)
      ST_OFF: begin
        rail_en_d = '0;
        idx_d     = '0;
        w_tmr_clr = 1'b1;
        if (enable) begin
          state_d      = ST_RAMP;
          rail_en_d[0] = 1'b1;
        end
      end

      ST_RAMP: begin
        if (w_pg_fail) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_rail_d = w_pg_fail_idx;
          w_tmr_clr    = 1'b1;
        end else if (!pg[idx_q] && w_tmr_last) begin
          // pg arriving on the timeout cycle still counts as good
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_rail_d = idx_q;
          w_tmr_clr    = 1'b1;
        end else if (!enable) begin
          state_d          = ST_DOWN;
          rail_en_d[idx_q] = 1'b0;
          w_tmr_clr        = 1'b1;
        end else if (pg[idx_q]) begin
          state_d   = ST_SETTLE;
          w_tmr_clr = 1'b1;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (w_pg_fail) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_rail_d = w_pg_fail_idx;
          w_tmr_clr    = 1'b1;
        end else if (!enable) begin
          state_d          = ST_DOWN;
          rail_en_d[idx_q] = 1'b0;
          w_tmr_clr        = 1'b1;
        end else if (w_tmr_last) begin
          w_tmr_clr = 1'b1;
          if (idx_q == c_last_idx) begin
            state_d = ST_UP;
          end else begin
            state_d               = ST_RAMP;
            idx_d                 = w_next_idx;
            rail_en_d[w_next_idx] = 1'b1;
          end
        end else begin
          w_tmr_inc = 1'b1;
        end
      end

      ST_UP: begin
        w_tmr_clr = 1'b1;
        if (w_pg_fail) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_rail_d = w_pg_fail_idx;
        end else if (!enable) begin
          state_d          = ST_DOWN;
          rail_en_d[idx_q] = 1'b0;
        end
      end

      // Reverse-order shutdown runs to completion; pg and enable are ignored.
      ST_DOWN: begin
        if (w_tmr_last) begin
          w_tmr_clr = 1'b1;
          if (idx_q == '0) begin
            state_d = ST_OFF;
          end else begin
            idx_d                 = w_prev_idx;
            rail_en_d[w_prev_idx] = 1'b0;
          end
        end else begin
          w_tmr_inc = 1'b1;
        end
      end

      ST_FAULT: begin
        rail_en_d = '0;
        w_tmr_clr = 1'b1;
        if (!enable) begin
          state_d      = ST_OFF;
          idx_d        = '0;
          fault_rail_d = '0;
        end
      end

      default: begin
        state_d      = ST_OFF;
        idx_d        = '0;
        rail_en_d    = '0;
        fault_rail_d = '0;
        w_tmr_clr    = 1'b1;
      end
    endcase
  end

  // Output decode
  always_comb begin : p_out
    rail_en    = rail_en_q;
    all_good   = (state_q == ST_UP);
    fault      = (state_q == ST_FAULT);
    fault_rail = fault_rail_q;
    state      = state_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rail_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rail_sequencer
// Description : Self-checking bench for rail_sequencer (3 rails, timeout 8,
//               settle 4). A behavioural model tracks how many rails are on
//               and how long the current phase has lasted; a compare process
//               checks every output against it each cycle. Directed scenarios
//               pin literal values, then a randomized phase drives enable,
//               power-good glitches, stuck rails and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rail_sequencer;

  localparam int NR  = 3;
  localparam int PGT = 8;
  localparam int SET = 4;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NR-1:0] pg;
  logic [NR-1:0] rail_en;
  logic          all_good;
  logic          fault;
  logic [1:0]    fault_rail;
  logic [2:0]    state;

  rail_sequencer #(
    .NUM_RAILS     (NR),
    .TIMER_WIDTH   (8),
    .PG_TIMEOUT    (PGT),
    .SETTLE_CYCLES (SET)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .enable     (enable),
    .pg         (pg),
    .rail_en    (rail_en),
    .all_good   (all_good),
    .fault      (fault),
    .fault_rail (fault_rail),
    .state      (state)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Plant: each pg follows its rail_en two cycles late, minus forced-low bits.
  logic [NR-1:0] prev_en = '0;
  logic [NR-1:0] kill    = '0;
  logic [NR-1:0] stuck   = '0;

  // ---------------- behavioural model ----------------
  // mode: 0 off, 1 ramp, 2 settle, 3 up, 4 down, 5 fault
  // on  : number of rails enabled (always a contiguous low block)
  typedef struct {
    int mode;
    int on;
    int wait_c;
    int fr;
  } model_t;

  model_t m = '{0, 0, 0, 0};

  function automatic int lowest_low(logic [NR-1:0] p, int count);
    for (int j = 0; j < count; j++) if (!p[j]) return j;
    return -1;
  endfunction

  function automatic model_t model_next(model_t c, logic en, logic [NR-1:0] p, logic rst);
    model_t n = c;
    int low;
    if (rst) return '{0, 0, 0, 0};
    case (c.mode)
      0: if (en) n = '{1, 1, 0, 0};
      1: begin
        low = lowest_low(p, c.on - 1);
        if (low >= 0)                                n = '{5, 0, 0, low};
        else if (!p[c.on-1] && c.wait_c == PGT - 1)  n = '{5, 0, 0, c.on - 1};
        else if (!en)                                n = '{4, c.on - 1, 0, c.fr};
        else if (p[c.on-1])                          n = '{2, c.on, 0, c.fr};
        else                                         n.wait_c = c.wait_c + 1;
      end
      2: begin
        low = lowest_low(p, c.on);
        if (low >= 0)                  n = '{5, 0, 0, low};
        else if (!en)                  n = '{4, c.on - 1, 0, c.fr};
        else if (c.wait_c == SET - 1)  n = (c.on == NR) ? '{3, NR, 0, c.fr} : '{1, c.on + 1, 0, c.fr};
        else                           n.wait_c = c.wait_c + 1;
      end
      3: begin
        low = lowest_low(p, NR);
        if (low >= 0)  n = '{5, 0, 0, low};
        else if (!en)  n = '{4, NR - 1, 0, c.fr};
      end
      4: begin
        if (c.wait_c == SET - 1) n = (c.on == 0) ? '{0, 0, 0, 0} : '{4, c.on - 1, 0, c.fr};
        else                     n.wait_c = c.wait_c + 1;
      end
      default: if (!en) n = '{0, 0, 0, 0};
    endcase
    return n;
  endfunction

  always @(posedge sysclk) m <= model_next(m, enable, pg, reset);

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge sysclk) begin
    if (chk_on) begin
      cmp("model rail_en", int'(rail_en), (1 << m.on) - 1);
      cmp("model all_good", int'(all_good), int'(m.mode == 3));
      cmp("model fault", int'(fault), int'(m.mode == 5));
      cmp("model state", int'(state), m.mode);
      if (m.mode == 5) cmp("model fault_rail", int'(fault_rail), m.fr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge sysclk);
    pg      = prev_en & ~(kill | stuck);
    prev_en = rail_en;
  endtask

  // Enable must already be 1; returns at the cycle all_good rises.
  task automatic power_up();
    tick();
    cmp("pu rail_en first", int'(rail_en), 3'b001);
    cmp("pu state ramp", int'(state), 1);
    repeat (5) tick();
    cmp("pu rail_en hold", int'(rail_en), 3'b001);
    tick();
    cmp("pu rail_en second", int'(rail_en), 3'b011);
    repeat (6) tick();
    cmp("pu rail_en third", int'(rail_en), 3'b111);
    repeat (6) tick();
    cmp("pu all_good", int'(all_good), 1);
    cmp("pu state up", int'(state), 3);
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pg     = '0;
    @(posedge sysclk);
    @(negedge sysclk);
    chk_on = 1'b1;
    cmp("reset rail_en", int'(rail_en), 0);
    cmp("reset state", int'(state), 0);
    cmp("reset fault", int'(fault), 0);
    cmp("reset all_good", int'(all_good), 0);
    cmp("reset fault_rail", int'(fault_rail), 0);
    reset = 1'b0;
    flush();

    // Normal power-up, then a one-cycle pg drop on rail 2
    enable = 1'b1;
    power_up();
    kill = 3'b100;
    tick();
    kill = 3'b000;
    tick();
    cmp("pgloss rail_en", int'(rail_en), 0);
    cmp("pgloss fault", int'(fault), 1);
    cmp("pgloss fault_rail", int'(fault_rail), 2);
    enable = 1'b0;
    tick();
    cmp("pgloss exit state", int'(state), 0);
    flush();

    // Timeout on rail 1
    stuck  = 3'b010;
    enable = 1'b1;
    tick();
    repeat (6) tick();
    cmp("timeout rail_en 011", int'(rail_en), 3'b011);
    repeat (7) tick();
    cmp("timeout not yet", int'(state), 1);
    tick();
    cmp("timeout rail_en", int'(rail_en), 0);
    cmp("timeout fault_rail", int'(fault_rail), 1);
    cmp("timeout state", int'(state), 5);
    repeat (2) tick();
    cmp("timeout latched", int'(fault), 1);
    enable = 1'b0;
    stuck  = 3'b000;
    tick();
    cmp("timeout exit fault", int'(fault), 0);
    cmp("timeout exit state", int'(state), 0);
    flush();

    // Power-down from UP, enable re-asserted mid-sequence is ignored
    enable = 1'b1;
    power_up();
    enable = 1'b0;
    tick();
    cmp("down rail_en 011", int'(rail_en), 3'b011);
    enable = 1'b1;
    repeat (3) tick();
    cmp("down hold 011", int'(rail_en), 3'b011);
    cmp("down state", int'(state), 4);
    tick();
    cmp("down rail_en 001", int'(rail_en), 3'b001);
    enable = 1'b0;
    repeat (4) tick();
    cmp("down rail_en 000", int'(rail_en), 3'b000);
    repeat (4) tick();
    cmp("down off", int'(state), 0);
    flush();

    // enable drop and pg[0] loss on the same cycle: fault wins
    enable = 1'b1;
    power_up();
    kill = 3'b001;
    tick();
    enable = 1'b0;
    kill   = 3'b000;
    tick();
    cmp("prio state", int'(state), 5);
    cmp("prio fault_rail", int'(fault_rail), 0);
    cmp("prio rail_en", int'(rail_en), 0);
    flush();

    // Reset while rail 1 settles, then enable honoured immediately
    enable = 1'b1;
    tick();
    repeat (9) tick();
    cmp("rst settle state", int'(state), 2);
    reset = 1'b1;
    tick();
    cmp("rst rail_en", int'(rail_en), 0);
    cmp("rst state", int'(state), 0);
    cmp("rst fault_rail", int'(fault_rail), 0);
    reset = 1'b0;
    tick();
    cmp("rst restart", int'(rail_en), 3'b001);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      kill = ($urandom_range(0, 59) == 0) ? NR'($urandom_range(1, 7)) : '0;
      if ($urandom_range(0, 199) == 0) stuck = NR'(1 << $urandom_range(0, NR - 1));
      else if ($urandom_range(0, 49) == 0) stuck = '0;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rail_sequencer.md
RAIL_SEQUENCER -- requirements
Module: rail_sequencer

Interface
REQ-001 SHALL have parameter NUM_RAILS, default 4: rail count, 1..16, rail 0 powers first.
REQ-002 SHALL have parameter TIMER_WIDTH, default 16: width of the shared cycle timer.
REQ-003 SHALL have parameter PG_TIMEOUT, default 1000: cycles to wait for power-good per rail, >=2, < 2^TIMER_WIDTH.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 100: settle delay per rail on power-up and on power-down, >=1, < 2^TIMER_WIDTH.
REQ-005 SHALL have sysclk  input  1  sole clock, free-running internal oscillator.
REQ-006 SHALL have reset  input  1  synchronous, active-high.
REQ-007 SHALL have enable  input  1  request rails on; treated as level, already synchronised.
REQ-008 SHALL have pg  input  NUM_RAILS  power-good per rail; bit i belongs to rail i.
REQ-009 SHALL have rail_en  output  NUM_RAILS  registered regulator enable per rail.
REQ-010 SHALL have all_good  output  1  high only in UP.
REQ-011 SHALL have fault  output  1  high only in FAULT.
REQ-012 SHALL have fault_rail  output  $clog2(NUM_RAILS) (min 1)  index of the failing rail, valid while fault=1.
REQ-013 SHALL have state  output  3  current FSM encoding, for LEDs and debug.

Function
REQ-014 SHALL implement FSM states OFF=0, RAMP=1, SETTLE=2, UP=3, DOWN=4, FAULT=5, with a rail index idx and one shared timer.
REQ-015 OFF: rail_en=0; enable=1 -> RAMP with idx=0, timer=0, and rail_en[0]=1 on the same edge.
REQ-016 RAMP: timer increments each cycle; pg[idx]=1 -> SETTLE with timer=0; timer==PG_TIMEOUT-1 with pg[idx]=0 -> FAULT with fault_rail=idx.
REQ-017 SETTLE: timer==SETTLE_CYCLES-1 -> UP if idx==NUM_RAILS-1; otherwise RAMP with idx+1, timer=0, and rail_en[idx+1]=1 on the same edge.
REQ-018 In RAMP, pg[j]=0 for any j<idx -> FAULT; in SETTLE and UP, pg[j]=0 for any enabled j -> FAULT; fault_rail = lowest such j.
REQ-019 UP: all_good=1 and rail_en all ones; the timer is held at 0.
REQ-020 enable=0 in RAMP, SETTLE or UP -> DOWN: rail_en[idx] cleared on the same edge, timer=0.
REQ-021 DOWN: timer==SETTLE_CYCLES-1 -> OFF if idx==0; otherwise idx-1 and rail_en[idx-1] cleared on the same edge, timer=0 (strict reverse order).
REQ-022 DOWN: pg is ignored and enable=1 is ignored; the sequence completes to OFF first.
REQ-023 FAULT: entered with rail_en=0 on the same edge (all rails off at once, no reverse order); fault=1 latched.
REQ-024 FAULT: exits to OFF only when enable=0 is sampled; fault_rail holds its value until then.
REQ-025 Simultaneous events: fault conditions take priority over enable=0; pg[idx] rising on the timeout cycle counts as good.
REQ-026 Timer SHALL never wrap; it is compared against the thresholds only, and TIMER_WIDTH is checked at elaboration.

Reset
REQ-027 reset=1 at a sysclk edge SHALL force OFF, idx=0, timer=0, rail_en=0, all_good=0, fault=0, fault_rail=0, state=0, regardless of current state (mid-sequence included).
REQ-028 After reset deasserts, enable=1 SHALL be honoured on the first following edge.

Structure
REQ-029 State encodings and the output width rule for fault_rail SHALL live in the shared include rail_seq_defs, reused by the existing DSP sequencer debug LEDs.
REQ-030 A single sub-module rail_seq_timer (clear, increment, terminal-compare) is permitted; everything else stays in rail_sequencer.

Verification (NUM_RAILS=3, PG_TIMEOUT=8, SETTLE_CYCLES=4)
REQ-031 Normal power-up: enable=1, each pg rises 2 cycles after its rail_en -> rail_en goes 001, 011, 111 at 6-cycle spacing; all_good=1 and state=3.
REQ-032 Timeout: pg[1] is never asserted -> 8 cycles after rail_en[1] rises, rail_en=000, fault=1, fault_rail=1, state=5; enable=0 then returns to OFF with fault=0.
REQ-033 Power-good loss in UP: drop pg[2] for 1 cycle -> next edge rail_en=000, fault=1, fault_rail=2.
REQ-034 Power-down from UP: enable=0 -> rail_en 011, 001, 000 at 4-cycle spacing, then OFF; re-asserting enable during DOWN has no effect.
REQ-035 Priority and reset: enable=0 and pg[0]=0 on the same cycle in UP -> FAULT with fault_rail=0; reset during SETTLE of rail 1 -> all outputs 0 on the next edge.
